// File: rtl/simd_vec_mem.sv
// Dual-view data memory: scalar byte port plus whole-line vector port with 1-cycle reads.
// Define SIMD_VEC_MEM_RING_EN to enable circular line addressing on the vector port.
`timescale 1ns/1ps
module simd_vec_mem #(
  parameter int LANES       = 16,
  parameter int LANE_W      = 8,
  parameter int DEPTH_LINES = 2048,
  parameter int SCALAR_W    = 32,
  localparam int LW         = $clog2(DEPTH_LINES),
  localparam int LNW        = $clog2(LANES),
  localparam int AW         = LW + LNW,
  localparam int DW         = LANES * LANE_W
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [AW-1:0]       s_addr,
  input  logic                s_we,
  input  logic [LANE_W-1:0]   s_wdata,
  output logic [SCALAR_W-1:0] s_rdata,
  input  logic                v_req,
  input  logic                v_we,
  input  logic [LW-1:0]       v_addr,
  input  logic [DW-1:0]       v_wdata,
  output logic                v_ready,
  output logic                v_rvalid,
  output logic [DW-1:0]       v_rdata,
  input  logic                ring_load,
  input  logic [LW-1:0]       ring_base,
  input  logic [LW:0]         ring_len,
  input  logic                ring_adv
);

  logic [LANES-1:0][LANE_W-1:0] mem_q [DEPTH_LINES];

  logic [SCALAR_W-1:0] s_rdata_q, s_rdata_d;
  logic [DW-1:0]       v_rdata_q, v_rdata_d;
  logic                v_rvalid_q, v_rvalid_d;
  logic                v_ready_q, v_ready_d;

  logic [LW-1:0]       s_line_s;
  logic [LNW-1:0]      s_lane_s;
  logic [LANE_W-1:0]   s_byte_s;
  logic                v_acc_s;
  logic                v_wr_s;
  logic                v_rd_s;
  logic                v_oor_s;
  logic [LW-1:0]       v_phys_s;
  logic [DW-1:0]       v_line_s;

  assign s_line_s = s_addr[AW-1:LNW];
  assign s_lane_s = s_addr[LNW-1:0];
  assign v_acc_s  = v_req && v_ready_q;

`ifdef SIMD_VEC_MEM_RING_EN
  logic [LW-1:0] base_q, base_d;
  logic [LW:0]   len_q, len_d;
  logic [LW:0]   head_q, head_d;
  logic [LW+1:0] sum_s, off_s;
  logic          unused_off_s;

  // Logical-to-physical line mapping; head < len keeps the wrap to a single subtract.
  always_comb begin
    sum_s = {1'b0, head_q} + {2'b00, v_addr};
    if (sum_s >= {1'b0, len_q}) begin
      off_s = sum_s - {1'b0, len_q};
    end else begin
      off_s = sum_s;
    end
    v_phys_s = base_q + off_s[LW-1:0];
    v_oor_s  = ({1'b0, v_addr} >= len_q);
  end

  assign unused_off_s = ^off_s[LW+1:LW];

  // Ring register next state: load beats advance, zero length clamps to one line.
  always_comb begin
    base_d    = base_q;
    len_d     = len_q;
    head_d    = head_q;
    v_ready_d = !ring_load;
    if (ring_load) begin
      base_d = ring_base;
      head_d = {(LW+1){1'b0}};
      if (ring_len == {(LW+1){1'b0}}) begin
        len_d = {{LW{1'b0}}, 1'b1};
      end else begin
        len_d = ring_len;
      end
    end else if (ring_adv) begin
      if (head_q + {{LW{1'b0}}, 1'b1} == len_q) begin
        head_d = {(LW+1){1'b0}};
      end else begin
        head_d = head_q + {{LW{1'b0}}, 1'b1};
      end
    end else begin
      head_d = head_q;
    end
  end

  // Ring registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      base_q <= {LW{1'b0}};
      len_q  <= (LW+1)'(DEPTH_LINES);
      head_q <= {(LW+1){1'b0}};
    end else begin
      base_q <= base_d;
      len_q  <= len_d;
      head_q <= head_d;
    end
  end
`else
  logic unused_ring_s;

  assign unused_ring_s = ^{ring_load, ring_base, ring_len, ring_adv};
  assign v_phys_s      = v_addr;
  assign v_oor_s       = 1'b0;
  assign v_ready_d     = 1'b1;
`endif

  assign v_wr_s = v_acc_s && v_we && !v_oor_s;
  assign v_rd_s = v_acc_s && !v_we;

  // Storage; the scalar lane write is issued last so it overrides a same-line vector write.
  always_ff @(posedge clk) begin
    if (v_wr_s) begin
      mem_q[v_phys_s] <= v_wdata;
    end
    if (s_we) begin
      mem_q[s_line_s][s_lane_s] <= s_wdata;
    end
  end

  // Read-side next state: old contents are sampled, so reads see pre-write data.
  always_comb begin
    s_byte_s   = mem_q[s_line_s][s_lane_s];
    v_line_s   = mem_q[v_phys_s];
    s_rdata_d  = SCALAR_W'($signed(s_byte_s));
    v_rvalid_d = v_rd_s;
    if (v_rd_s) begin
      if (v_oor_s) begin
        v_rdata_d = {DW{1'b0}};
      end else begin
        v_rdata_d = v_line_s;
      end
    end else begin
      v_rdata_d = v_rdata_q;
    end
  end

  // Output registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      s_rdata_q  <= {SCALAR_W{1'b0}};
      v_rdata_q  <= {DW{1'b0}};
      v_rvalid_q <= 1'b0;
      v_ready_q  <= 1'b0;
    end else begin
      s_rdata_q  <= s_rdata_d;
      v_rdata_q  <= v_rdata_d;
      v_rvalid_q <= v_rvalid_d;
      v_ready_q  <= v_ready_d;
    end
  end

  assign s_rdata  = s_rdata_q;
  assign v_rdata  = v_rdata_q;
  assign v_rvalid = v_rvalid_q;
  assign v_ready  = v_ready_q;

endmodule

// File: tb/tb_simd_vec_mem.sv
// Directed plus random bench for simd_vec_mem against a line-array reference model.
`timescale 1ns/1ps
module tb_simd_vec_mem;
  localparam int LANES = 16;
  localparam int LANE_W = 8;
  localparam int DEPTH = 2048;
  localparam int SW = 32;
  localparam int LW = 11;
  localparam int AW = 15;
  localparam int DW = 128;
  localparam int NL = 16;
`ifdef SIMD_VEC_MEM_RING_EN
  localparam bit RING = 1'b1;
`else
  localparam bit RING = 1'b0;
`endif

  logic clk, reset;
  logic [AW-1:0] s_addr;
  logic s_we;
  logic [LANE_W-1:0] s_wdata;
  logic [SW-1:0] s_rdata;
  logic v_req, v_we, v_ready, v_rvalid;
  logic [LW-1:0] v_addr;
  logic [DW-1:0] v_wdata, v_rdata;
  logic ring_load, ring_adv;
  logic [LW-1:0] ring_base;
  logic [LW:0] ring_len;

  simd_vec_mem dut (
    .clk(clk), .reset(reset),
    .s_addr(s_addr), .s_we(s_we), .s_wdata(s_wdata), .s_rdata(s_rdata),
    .v_req(v_req), .v_we(v_we), .v_addr(v_addr), .v_wdata(v_wdata),
    .v_ready(v_ready), .v_rvalid(v_rvalid), .v_rdata(v_rdata),
    .ring_load(ring_load), .ring_base(ring_base), .ring_len(ring_len), .ring_adv(ring_adv)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [DW-1:0] mdl [DEPTH];
  int m_base, m_len, m_head;
  logic m_ready, m_rvalid;
  logic [DW-1:0] m_rdata;
  logic [SW-1:0] m_srdata;
  bit s_live;
  int checks, errors;

  task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // One clock: predict from the model, advance, then compare.
  task automatic step();
    logic acc, oor, n_rvalid, n_ready, rst_now;
    int p, sl, sn;
    logic [DW-1:0] n_rdata;
    logic [SW-1:0] n_srdata;
    logic [LANE_W-1:0] b;
    rst_now = reset;
    acc = v_req && m_ready;
    oor = RING && (int'(v_addr) >= m_len);
    p = RING ? (m_base + (m_head + int'(v_addr)) % m_len) % DEPTH : int'(v_addr);
    sl = int'(s_addr) / LANES;
    sn = int'(s_addr) % LANES;
    b = mdl[sl][sn*LANE_W +: LANE_W];
    n_srdata = reset ? '0 : SW'($signed(b));
    n_rvalid = acc && !v_we && !reset;
    if (reset) n_rdata = '0;
    else if (acc && !v_we) n_rdata = oor ? '0 : mdl[p];
    else n_rdata = m_rdata;
    if (acc && v_we && !oor) mdl[p] = v_wdata;
    if (s_we) mdl[sl][sn*LANE_W +: LANE_W] = s_wdata;
    if (reset) begin
      m_base = 0; m_len = DEPTH; m_head = 0;
    end else if (RING && ring_load) begin
      m_base = int'(ring_base);
      m_len = (ring_len == 0) ? 1 : int'(ring_len);
      m_head = 0;
    end else if (RING && ring_adv) begin
      m_head = (m_head + 1) % m_len;
    end
    n_ready = !reset && !(RING && ring_load);
    @(posedge clk);
    #1;
    m_ready = n_ready; m_rvalid = n_rvalid; m_rdata = n_rdata; m_srdata = n_srdata;
    chk("v_ready", DW'(v_ready), DW'(m_ready));
    chk("v_rvalid", DW'(v_rvalid), DW'(m_rvalid));
    chk("v_rdata", v_rdata, m_rdata);
    if (s_live || rst_now) chk("s_rdata", DW'(s_rdata), DW'(m_srdata));
  endtask

  task automatic idle();
    v_req = 1'b0; v_we = 1'b0; s_we = 1'b0; ring_load = 1'b0; ring_adv = 1'b0;
  endtask

  task automatic vop(input logic we, input int a, input logic [DW-1:0] d);
    v_req = 1'b1; v_we = we; v_addr = LW'(a); v_wdata = d;
  endtask

  initial begin
    logic [DW-1:0] d;
    logic [DW-1:0] tag_a, tag_b, tag_c, tag_d, tag_e;
    tag_a = {16{8'hA1}}; tag_b = {16{8'hB2}}; tag_c = {16{8'hC3}};
    tag_d = {16{8'hD4}}; tag_e = {16{8'h5E}};
    checks = 0; errors = 0; s_live = 1'b0;
    m_base = 0; m_len = DEPTH; m_head = 0;
    m_ready = 1'b0; m_rvalid = 1'b0; m_rdata = '0; m_srdata = '0;
    reset = 1'b1; s_addr = '0; s_wdata = '0; v_addr = '0; v_wdata = '0;
    ring_base = '0; ring_len = '0;
    idle();

    // Reset state
    step(); step();
    chk("rst_v_ready", DW'(v_ready), DW'(1'b0));
    chk("rst_v_rdata", v_rdata, '0);
    reset = 1'b0;
    step();
    chk("ready_after_rst", DW'(v_ready), DW'(1'b1));

    // Initialise the working lines
    for (int i = 0; i < NL; i++) begin
      vop(1'b1, i, {$urandom, $urandom, $urandom, $urandom});
      step();
    end
    idle();
    step();
    s_live = 1'b1;

    // Scalar stores, vector read of line 2
    for (int i = 0; i < 16; i++) begin
      s_we = 1'b1; s_addr = AW'(32 + i); s_wdata = 8'(i);
      step();
    end
    idle();
    vop(1'b0, 2, '0);
    step();
    chk("s2v_rvalid", DW'(v_rvalid), DW'(1'b1));
    chk("s2v_rdata", v_rdata, 128'h0F0E0D0C0B0A09080706050403020100);

    // Sign extension
    d = {$urandom, $urandom, $urandom, $urandom};
    d[3*8 +: 8] = 8'h80;
    d[4*8 +: 8] = 8'h7F;
    vop(1'b1, 5, d);
    step();
    idle();
    s_addr = AW'(16'h53);
    step();
    chk("sext_neg", DW'(s_rdata), DW'(32'hFFFFFF80));
    s_addr = AW'(16'h54);
    step();
    chk("sext_pos", DW'(s_rdata), DW'(32'h0000007F));

    // Scalar + vector write collision on line 3
    s_we = 1'b1; s_addr = AW'(16'h31); s_wdata = 8'hAA;
    vop(1'b1, 3, {16{8'h55}});
    step();
    idle();
    vop(1'b0, 3, '0);
    step();
    chk("collide", v_rdata, 128'h5555_5555_5555_5555_5555_5555_5555_AA55);
    idle();

`ifdef SIMD_VEC_MEM_RING_EN
    // Ring wrap with base 10, len 3
    ring_load = 1'b1; ring_base = LW'(10); ring_len = (LW+1)'(3);
    step();
    chk("ring_ready_low", DW'(v_ready), DW'(1'b0));
    ring_load = 1'b0;
    vop(1'b0, 0, '0);
    step();
    chk("ring_ready_back", DW'(v_ready), DW'(1'b1));
    chk("ring_ignored", DW'(v_rvalid), DW'(1'b0));
    vop(1'b1, 0, tag_a); step();
    vop(1'b1, 1, tag_b); step();
    vop(1'b1, 2, tag_c); step();
    idle();
    ring_adv = 1'b1; step(); step();
    ring_adv = 1'b0;
    s_addr = AW'(12 * 16);
    vop(1'b0, 0, '0); step();
    chk("ring_rd0", v_rdata, tag_c);
    chk("ring_phys12", DW'(s_rdata), DW'(32'hFFFFFFC3));
    vop(1'b0, 1, '0); step();
    chk("ring_rd1", v_rdata, tag_a);
    vop(1'b0, 2, '0); step();
    chk("ring_rd2", v_rdata, tag_b);
    vop(1'b0, 3, tag_e); step();
    chk("ring_oor_data", v_rdata, '0);
    chk("ring_oor_valid", DW'(v_rvalid), DW'(1'b1));
    idle();
`else
    // Ring ports ignored: v_addr 4 is physical line 4
    ring_load = 1'b1; ring_base = LW'(10); ring_len = (LW+1)'(3);
    vop(1'b1, 4, tag_e);
    step();
    chk("noring_ready", DW'(v_ready), DW'(1'b1));
    ring_load = 1'b0;
    s_addr = AW'(16'h40);
    vop(1'b0, 4, '0);
    step();
    chk("noring_rd", v_rdata, tag_e);
    chk("noring_phys4", DW'(s_rdata), DW'(32'h0000005E));
    idle();
`endif

    // Reset in the same cycle as an accepted read
    vop(1'b0, 2, '0);
    reset = 1'b1;
    step();
    chk("rst_rd_rvalid", DW'(v_rvalid), DW'(1'b0));
    chk("rst_rd_ready", DW'(v_ready), DW'(1'b0));
    chk("rst_rd_rdata", v_rdata, '0);
    idle();
    reset = 1'b0;
    step();
    chk("rst_rd_ready_back", DW'(v_ready), DW'(1'b1));

    // Write accepted in a reset cycle still commits
    vop(1'b1, 7, tag_d);
    reset = 1'b1;
    step();
    idle();
    reset = 1'b0;
    step();
    vop(1'b0, 7, '0);
    step();
    chk("rst_wr_commit", v_rdata, tag_d);
    idle();

    // Random traffic
    for (int i = 0; i < 400; i++) begin
      s_addr = AW'($urandom_range(0, NL * LANES - 1));
      s_we = ($urandom_range(0, 2) == 0);
      s_wdata = 8'($urandom);
      v_req = ($urandom_range(0, 3) != 0);
      v_we = 1'($urandom_range(0, 1));
      v_addr = LW'($urandom_range(0, NL - 1));
      v_wdata = {$urandom, $urandom, $urandom, $urandom};
      ring_load = ($urandom_range(0, 15) == 0);
      ring_adv = ($urandom_range(0, 3) == 0);
      ring_base = LW'($urandom_range(0, 7));
      ring_len = (LW+1)'($urandom_range(0, 8));
      step();
    end
    idle();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not reach the summary");
    $fatal(1, "timeout");
  end

endmodule
